// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer display path.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package reaction_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_E     = 7'h06;
    localparam seg_t SEG_BLANK = 7'h7F;

    // Result value the timer reports when the subject never reacted.
    localparam logic [15:0] TIMEOUT_CODE = 16'h9999;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD inputs show 'E'.
module bcd_to_7seg
    import reaction_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    // Table lookup; anything above 9 is flagged with the E glyph.
    always_comb begin
        seg = SEG_E;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/reaction_disp_scan.sv
// Captures the reaction timer result digits and scans them onto a common-anode
// 4-digit seven-segment display with leading-zero blanking and a fixed decimal point.
// Optional timeout blinking is enabled by defining REACTION_DISP_BLINK_EN.
module reaction_disp_scan
    import reaction_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned DP_POS      = 3,
    parameter int unsigned BLINK_TICKS = 64
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       rs_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pre_q;
    logic          tick;
    logic [1:0]    idx_q;
    logic          load_q;
    logic [15:0]   shadow_q;
    logic          valid_q;

    logic [3:0]    cur_digit;
    logic          higher_zero;
    logic          blank;
    logic          is_dp;
    seg_t          dec_seg;
    logic          blink_off;

    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign tick = (pre_q == PW'(SCAN_DIV - 1));

    // Slot prescaler, digit index and the one-cycle-late output load strobe.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q  <= '0;
            idx_q  <= 2'd0;
            load_q <= 1'b0;
        end else begin
            pre_q  <= tick ? '0 : pre_q + 1'b1;
            load_q <= tick;
            if (tick) begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    // Result capture; valid is sticky until reset.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow_q <= 16'h0000;
            valid_q  <= 1'b0;
        end else if (rs_en) begin
            shadow_q <= {d3, d2, d1, d0};
            valid_q  <= 1'b1;
        end
    end

`ifdef REACTION_DISP_BLINK_EN
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;

    // Blink half-period counter advanced once per scan tick.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign blink_off = valid_q && (shadow_q == TIMEOUT_CODE) && phase_q;
`else
    assign blink_off = 1'b0;
`endif

    // Select the current digit and decide whether it is a leading zero.
    always_comb begin
        cur_digit   = shadow_q[3:0];
        higher_zero = 1'b0;
        case (idx_q)
            2'd0: begin
                cur_digit   = shadow_q[3:0];
                higher_zero = 1'b0;
            end
            2'd1: begin
                cur_digit   = shadow_q[7:4];
                higher_zero = (shadow_q[15:4] == 12'h000);
            end
            2'd2: begin
                cur_digit   = shadow_q[11:8];
                higher_zero = (shadow_q[15:8] == 8'h00);
            end
            default: begin
                cur_digit   = shadow_q[15:12];
                higher_zero = (shadow_q[15:12] == 4'h0);
            end
        endcase
    end

    assign is_dp = (32'(idx_q) == DP_POS);
    assign blank = (idx_q != 2'd0) && !is_dp && higher_zero;

    bcd_to_7seg u_dec (
        .bcd(cur_digit),
        .seg(dec_seg)
    );

    // Next display pattern for the freshly advanced digit index.
    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = dec_seg;
        dp_d  = !(valid_q && is_dp);
        if (!valid_q) begin
            seg_d = SEG_DASH;
        end else if (blank) begin
            seg_d = SEG_BLANK;
        end
        if (blink_off) begin
            an_d = 4'b1111;
        end
    end

    // Registered display outputs, loaded the cycle after each tick.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (load_q) begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_reaction_disp_scan.sv
// Self-checking bench for reaction_disp_scan with SCAN_DIV=4, DP_POS=3, BLINK_TICKS=2.
// Honours REACTION_DISP_BLINK_EN when the design is built with it.
module tb_reaction_disp_scan;

    logic       clk = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] d0 = 4'h0;
    logic [3:0] d1 = 4'h0;
    logic [3:0] d2 = 4'h0;
    logic [3:0] d3 = 4'h0;
    logic       rs_en = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad = 0;

    reaction_disp_scan #(
        .SCAN_DIV(4),
        .DP_POS(3),
        .BLINK_TICKS(2)
    ) dut (
        .clk(clk),
        .RESET_N(RESET_N),
        .d0(d0),
        .d1(d1),
        .d2(d2),
        .d3(d3),
        .rs_en(rs_en),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    always #5 clk = ~clk;

    // Behavioural model: edges since reset, shadow digits and valid flag.
    int         pre;
    logic [3:0] ms[4];
    bit         mv;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    function automatic logic [6:0] glyph(logic [3:0] v);
        logic [6:0] t[10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (v > 4'd9) return 7'h06;
        return t[v];
    endfunction

    function automatic logic [11:0] disp(int i, logic [3:0] s0, logic [3:0] s1,
                                         logic [3:0] s2, logic [3:0] s3, bit v, bit blink);
        logic [3:0] s[4];
        logic [3:0] a;
        logic [6:0] g;
        logic       p;
        bit         allz;
        s = '{s0, s1, s2, s3};
        a = 4'b1111;
        a[i] = 1'b0;
        allz = 1'b1;
        for (int j = i; j < 4; j++) if (s[j] != 4'h0) allz = 1'b0;
        if (!v) g = 7'h3F;
        else if (i > 0 && i != 3 && allz) g = 7'h7F;
        else g = glyph(s[i]);
        p = !(v && i == 3);
        if (blink) a = 4'b1111;
        return {a, g, p};
    endfunction

    function automatic bit blink_now(int k, bit v, logic [3:0] s0, logic [3:0] s1,
                                     logic [3:0] s2, logic [3:0] s3);
`ifdef REACTION_DISP_BLINK_EN
        return v && s0 == 4'd9 && s1 == 4'd9 && s2 == 4'd9 && s3 == 4'd9 && ((k / 2) % 2 == 1);
`else
        return 1'b0;
`endif
    endfunction

    // Model: outputs load the edge after every 4th edge, showing ticks-so-far mod 4.
    always @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pre     <= 0;
            mv      <= 1'b0;
            ms      <= '{4'h0, 4'h0, 4'h0, 4'h0};
            exp_an  <= 4'b1111;
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
        end else begin
            if (pre > 0 && pre % 4 == 0) begin
                {exp_an, exp_seg, exp_dp} <= disp((pre / 4) % 4, ms[0], ms[1], ms[2], ms[3], mv,
                    blink_now(pre / 4, mv, ms[0], ms[1], ms[2], ms[3]));
            end
            if (rs_en) begin
                ms <= '{d0, d1, d2, d3};
                mv <= 1'b1;
            end
            pre <= pre + 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            total++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
                bad++;
                $display("FAIL model t=%0t an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                         $time, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
    end

    task automatic check_now(string name, logic [3:0] a, logic [6:0] g, logic p);
        total++;
        if (an !== a || seg !== g || dp !== p) begin
            bad++;
            $display("FAIL %s an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                     name, an, seg, dp, a, g, p);
        end
    endtask

    // Wait (bounded) for the given anode pattern, then check segments literally.
    task automatic wait_slot(string name, logic [3:0] a, logic [6:0] g, logic p);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (an === a) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s timeout an=%b required an=%b", name, an, a);
        end else begin
            check_now(name, a, g, p);
        end
    endtask

    task automatic capture(logic [3:0] v3, logic [3:0] v2, logic [3:0] v1, logic [3:0] v0);
        @(negedge clk);
        d3 = v3;
        d2 = v2;
        d1 = v1;
        d0 = v0;
        rs_en = 1'b1;
        @(negedge clk);
        rs_en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_now("reset_blank", 4'b1111, 7'h7F, 1'b1);
        RESET_N = 1'b1;
        wait_slot("dash_1", 4'b1101, 7'h3F, 1'b1);
        wait_slot("dash_2", 4'b1011, 7'h3F, 1'b1);
        wait_slot("dash_3", 4'b0111, 7'h3F, 1'b1);
        wait_slot("dash_0", 4'b1110, 7'h3F, 1'b1);

        capture(4'd0, 4'd2, 4'd5, 4'd7);
        wait_slot("r0257_d0", 4'b1110, 7'h78, 1'b1);
        wait_slot("r0257_d1", 4'b1101, 7'h12, 1'b1);
        wait_slot("r0257_d2", 4'b1011, 7'h24, 1'b1);
        wait_slot("r0257_d3", 4'b0111, 7'h40, 1'b0);

        capture(4'd0, 4'd0, 4'd0, 4'd5);
        wait_slot("r0005_d0", 4'b1110, 7'h12, 1'b1);
        wait_slot("r0005_d1", 4'b1101, 7'h7F, 1'b1);
        wait_slot("r0005_d2", 4'b1011, 7'h7F, 1'b1);
        wait_slot("r0005_d3", 4'b0111, 7'h40, 1'b0);

        capture(4'd0, 4'd0, 4'd0, 4'hC);
        wait_slot("r000C_d0", 4'b1110, 7'h06, 1'b1);
        wait_slot("r000C_d1", 4'b1101, 7'h7F, 1'b1);
        wait_slot("r000C_d2", 4'b1011, 7'h7F, 1'b1);
        wait_slot("r000C_d3", 4'b0111, 7'h40, 1'b0);

        capture(4'd0, 4'hA, 4'd0, 4'd1);
        wait_slot("r0A01_d1", 4'b1101, 7'h40, 1'b1);
        wait_slot("r0A01_d2", 4'b1011, 7'h06, 1'b1);

        // Reset in the middle of a slot blanks the outputs at once.
        @(negedge clk);
        #2 RESET_N = 1'b0;
        #1 check_now("async_reset", 4'b1111, 7'h7F, 1'b1);
        @(negedge clk);
        RESET_N = 1'b1;
        repeat (4) @(negedge clk);
        check_now("post_reset_4", 4'b1111, 7'h7F, 1'b1);
        @(negedge clk);
        check_now("post_reset_5", 4'b1101, 7'h3F, 1'b1);

        capture(4'd9, 4'd9, 4'd9, 4'd9);
`ifdef REACTION_DISP_BLINK_EN
        wait_slot("blink_off", 4'b1111, 7'h10, 1'b1);
`else
        wait_slot("r9999_d3", 4'b0111, 7'h10, 1'b0);
        wait_slot("r9999_d0", 4'b1110, 7'h10, 1'b1);
`endif
        capture(4'd1, 4'd2, 4'd3, 4'd4);
        wait_slot("r1234_d0", 4'b1110, 7'h19, 1'b1);
        wait_slot("r1234_d1", 4'b1101, 7'h30, 1'b1);
        wait_slot("r1234_d2", 4'b1011, 7'h24, 1'b1);
        wait_slot("r1234_d3", 4'b0111, 7'h79, 1'b0);
        repeat (16) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
